// File: rtl/accel_servo_pkg.sv
// accel_servo_pkg: shared pulse-width constants and the tilt-to-pulse mapping for the servo controller.
package accel_servo_pkg;
    localparam int PULSE_MIN_US = 1000;
    localparam int PULSE_MID_US = 1500;
    localparam int PULSE_MAX_US = 2000;
    localparam int PULSE_W      = 11;
    localparam int SUM_W        = 18;
    localparam int MAP_MUL      = 125;
    localparam int MAP_SHIFT    = 6;

    // Clamp to +/-clamp, scale onto +/-500 us with a floor shift, and keep the result inside the servo range.
    function automatic logic [PULSE_W-1:0] map_pulse(input int avg, input int clamp);
        int c;
        int p;
        c = (avg > clamp) ? clamp : ((avg < -clamp) ? -clamp : avg);
        p = PULSE_MID_US + ((c * MAP_MUL) >>> MAP_SHIFT);
        p = (p < PULSE_MIN_US) ? PULSE_MIN_US : ((p > PULSE_MAX_US) ? PULSE_MAX_US : p);
        return p[PULSE_W-1:0];
    endfunction
endpackage

// File: rtl/axis_avg_map.sv
// axis_avg_map: per-axis sample history, running sum, and registered clamp/map to a servo pulse width.
module axis_avg_map
    import accel_servo_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int CLAMP    = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                capture,
    input  logic                load,
    input  logic signed [15:0]  data,
    output logic [PULSE_W-1:0]  pulse_us
);
    localparam int DEPTH = 1 << AVG_LOG2;

    logic signed [15:0]      hist_q [DEPTH];
    logic signed [15:0]      hist_d [DEPTH];
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [PULSE_W-1:0]      pulse_q, pulse_d;

    always_comb begin
        hist_d  = hist_q;
        sum_d   = sum_q;
        pulse_d = pulse_q;
        if (capture) begin
            sum_d     = sum_q + SUM_W'(data) - SUM_W'(hist_q[DEPTH-1]);
            hist_d[0] = data;
            for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
        // load arrives one cycle after capture, so sum_q already includes the new sample
        if (load) pulse_d = map_pulse(int'(sum_q >>> AVG_LOG2), CLAMP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q  <= '{default: '0};
            sum_q   <= '0;
            pulse_q <= PULSE_W'(PULSE_MID_US);
        end else begin
            hist_q  <= hist_d;
            sum_q   <= sum_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_us = pulse_q;
endmodule

// File: rtl/accel_servo_ctrl.sv
// accel_servo_ctrl: turns accelerometer samples into averaged servo pulse widths and drives two
// frame-synchronous hobby-servo PWM outputs.
module accel_servo_ctrl
    import accel_servo_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int PWM_FREQ = 50,
    parameter int AVG_LOG2 = 2,
    parameter int CLAMP    = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                data_update,
    input  logic signed [15:0]  data_x,
    input  logic signed [15:0]  data_y,
    input  logic                enable,
    output logic [PULSE_W-1:0]  pulse_x_us,
    output logic [PULSE_W-1:0]  pulse_y_us,
    output logic                sample_valid,
    output logic                servo_x,
    output logic                servo_y
);
    localparam int DIV      = CLK_FREQ / 1_000_000;
    localparam int FRAME_US = 1_000_000 / PWM_FREQ;
    localparam int PW       = $clog2(DIV + 1);
    localparam int FW       = $clog2(FRAME_US + 1);

    logic               upd_q, cap_q, valid_q;
    logic [PW-1:0]      pre_q, pre_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic [PULSE_W-1:0] wx_q, wx_d, wy_q, wy_d;
    logic               run_q, run_d, sx_q, sx_d, sy_q, sy_d;
    logic               capture, tick, wrap, start;

    axis_avg_map #(.AVG_LOG2(AVG_LOG2), .CLAMP(CLAMP)) u_x (
        .clk(clk), .reset_n(reset_n), .capture(capture), .load(cap_q), .data(data_x), .pulse_us(pulse_x_us)
    );
    axis_avg_map #(.AVG_LOG2(AVG_LOG2), .CLAMP(CLAMP)) u_y (
        .clk(clk), .reset_n(reset_n), .capture(capture), .load(cap_q), .data(data_y), .pulse_us(pulse_y_us)
    );

    always_comb begin
        capture = data_update & ~upd_q;
        tick    = pre_q == PW'(DIV - 1);
        wrap    = tick && frame_q == FW'(FRAME_US - 1);
        start   = pre_q == '0 && frame_q == '0;
        pre_d   = tick ? '0 : pre_q + PW'(1);
        frame_d = wrap ? '0 : (tick ? frame_q + FW'(1) : frame_q);
        // widths latch on the wrap edge itself, so a pulse update landing on that edge waits a frame
        wx_d    = wrap ? pulse_x_us : wx_q;
        wy_d    = wrap ? pulse_y_us : wy_q;
        run_d   = start ? enable : (run_q & enable);
        sx_d    = run_d && (int'(frame_q) < int'(wx_q));
        sy_d    = run_d && (int'(frame_q) < int'(wy_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_q   <= 1'b0;
            cap_q   <= 1'b0;
            valid_q <= 1'b0;
            pre_q   <= '0;
            frame_q <= '0;
            wx_q    <= PULSE_W'(PULSE_MID_US);
            wy_q    <= PULSE_W'(PULSE_MID_US);
            run_q   <= 1'b0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
        end else begin
            upd_q   <= data_update;
            cap_q   <= capture;
            valid_q <= cap_q;
            pre_q   <= pre_d;
            frame_q <= frame_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            run_q   <= run_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    assign sample_valid = valid_q;
    assign servo_x      = sx_q;
    assign servo_y      = sy_q;
endmodule
